// File: rtl/imm_pkg.sv
// Shared types for the immediate decode stage: format select encoding and width default.
package imm_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      IMM_I       = 3'd0,
      IMM_S       = 3'd1,
      IMM_B       = 3'd2,
      IMM_U       = 3'd3,
      IMM_J       = 3'd4,
      IMM_CSR     = 3'd5,
      IMM_SHAMT   = 3'd6,
      IMM_ILLEGAL = 3'd7
   } imm_fmt_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: gathers the fields of each format into a
// 32-bit value, then sign-extends that value to XLEN.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     instr,
   input  imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   logic [31:0] v32;
   logic        unused_bits;

   assign unused_bits = &{1'b0, instr[6:0]};

   // Zero-extended formats keep v32[31]=0, so one sign-extension path serves all.
   always_comb begin
      v32     = '0;
      illegal = 1'b0;
      case (fmt)
         IMM_I:   v32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   v32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   v32 = {instr[31:12], 12'b0};
         IMM_J:   v32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_CSR: v32 = {27'b0, instr[19:15]};
         IMM_SHAMT: begin
            if (XLEN == 64) begin
               v32 = {26'b0, instr[25:20]};
            end else if (instr[25]) begin
               illegal = 1'b1;
            end else begin
               v32 = {27'b0, instr[24:20]};
            end
         end
         default: illegal = 1'b1;
      endcase
      imm = XLEN'($signed(v32));
   end

endmodule

// File: rtl/imm_decode_stage.sv
// One-cycle immediate decode stage with a 2-entry skid buffer (output + skid)
// and a saturating counter of accepted illegal requests.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int TAG_W = 32,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [2:0]       imm_ctrl,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_ext,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic [ERR_W-1:0] err_cnt
);

   // Handshake: a request transfers on a rising edge where in_valid && in_ready;
   // a result transfers where out_valid && out_ready. out_* hold while stalled.

   logic [XLEN-1:0]  ext_imm;
   logic             ext_illegal;
   logic             skid_valid;
   logic [XLEN-1:0]  skid_imm;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_illegal;
   logic             accept;
   logic             consume;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (instr),
      .fmt     (imm_fmt_e'(imm_ctrl)),
      .imm     (ext_imm),
      .illegal (ext_illegal)
   );

   // in_ready comes only from the skid flop, never from out_ready.
   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         imm_ext      <= '0;
         out_tag      <= '0;
         out_illegal  <= 1'b0;
         skid_valid   <= 1'b0;
         skid_imm     <= '0;
         skid_tag     <= '0;
         skid_illegal <= 1'b0;
         err_cnt      <= '0;
      end else begin
         if (consume) begin
            if (skid_valid) begin
               imm_ext     <= skid_imm;
               out_tag     <= skid_tag;
               out_illegal <= skid_illegal;
               skid_valid  <= 1'b0;
            end else if (accept) begin
               imm_ext     <= ext_imm;
               out_tag     <= in_tag;
               out_illegal <= ext_illegal;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            if (!out_valid) begin
               out_valid   <= 1'b1;
               imm_ext     <= ext_imm;
               out_tag     <= in_tag;
               out_illegal <= ext_illegal;
            end else begin
               skid_valid   <= 1'b1;
               skid_imm     <= ext_imm;
               skid_tag     <= in_tag;
               skid_illegal <= ext_illegal;
            end
         end

         if (accept && ext_illegal && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning output immediate width (legal values 32 or 64).
REQ-002 SHALL have parameter TAG_W, default 32, meaning width of the sideband tag (PC/rd) carried alongside each immediate.
REQ-003 SHALL have parameter ERR_W, default 8, meaning width of the illegal-format counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream holds a valid request.
REQ-007 in_ready  output  1  stage can accept a request this cycle.
REQ-008 instr  input  32  full instruction word.
REQ-009 imm_ctrl  input  3  format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 CSR-zimm, 6 SHAMT, 7 illegal.
REQ-010 in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 imm_ext  output  XLEN  extended immediate.
REQ-014 out_tag  output  TAG_W  tag matching imm_ext.
REQ-015 out_illegal  output  1  result came from imm_ctrl=7 or an unsupported format.
REQ-016 err_cnt  output  ERR_W  saturating count of accepted illegal requests.

Function
REQ-017 Formats SHALL be as follows, sign-extended from instr[31] to XLEN unless stated:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}, sign-extended.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-018 CSR-zimm SHALL be instr[19:15] zero-extended.
REQ-019 SHAMT SHALL be instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64), zero-extended.
REQ-020 imm_ctrl=7 SHALL produce imm_ext=0 with out_illegal=1.
REQ-021 With XLEN=32, SHAMT SHALL have instr[25]=1 flagged illegal with imm_ext=0.
REQ-022 A request SHALL be accepted when in_valid && in_ready; a result SHALL be consumed when out_valid && out_ready.
REQ-023 Latency SHALL be exactly 1 cycle: a request accepted at edge N with the output register empty or draining appears at out_* after edge N.
REQ-024 Storage SHALL be a 2-entry skid: output register plus one skid register.
REQ-025 Accept when output empty or consumed SHALL load the output register; accept while output held (out_valid && !out_ready) SHALL load skid.
REQ-026 On consume with skid full, skid SHALL move to output in the same edge; a simultaneous accept is impossible because in_ready=0 while skid is full.
REQ-027 in_ready SHALL equal !skid_valid, driven from a register with no combinational path from out_ready.
REQ-028 out_* SHALL remain stable while out_valid && !out_ready.
REQ-029 Ordering SHALL be strictly FIFO, with no drops and no duplicates.
REQ-030 err_cnt SHALL increment on each accepted illegal request and saturate at all-ones.

Reset
REQ-031 On reset SHALL set out_valid=0, skid_valid=0, in_ready=1, imm_ext=0, out_tag=0, out_illegal=0, err_cnt=0.
REQ-032 Reset mid-transfer SHALL discard both entries; the first accept after reset deassertion SHALL behave as from empty.

Structure
REQ-033 Package imm_pkg SHALL hold the imm_fmt_e enum (IMM_I..IMM_ILLEGAL, 3 bits) and the XLEN default.
REQ-034 Field extraction SHALL be a combinational sub-module imm_extract (instr, fmt -> imm, illegal), instantiated once before the skid logic.

Verification
REQ-035 I-format: instr=0xFFF00093, imm_ctrl=0, out_ready=1 -> next cycle imm_ext=0xFFFFFFFF, out_illegal=0.
REQ-036 B and J formats:
- instr=0xFE000EE3, imm_ctrl=2 -> imm_ext=0xFFFFFFFC.
- instr=0xFF9FF06F, imm_ctrl=4 -> imm_ext=0xFFFFFFF8.
REQ-037 U-format with XLEN=64: instr=0x80000037, imm_ctrl=3 -> imm_ext=0xFFFFFFFF80000000.
REQ-038 Backpressure: three back-to-back requests with tags 1,2,3 and out_ready=0 -> in_ready falls after the 2nd accept and the 3rd is held; then raising out_ready -> tags emerge 1,2,3 in order, each stable while stalled.
REQ-039 Illegal formats: 260 accepted imm_ctrl=7 requests with ERR_W=8 -> every result has out_illegal=1, imm_ext=0, and err_cnt saturates at 255.
REQ-040 Reset with both entries full -> out_valid=0 and in_ready=1 the next cycle, with no stale result emitted.
